// File: rtl/scoreboard_display_sequencer.sv
// Rotating scoreboard display sequencer: blinks "P<n>" for each player, then shows
// that player's score, with hold, skip and digit sanitising.
module scoreboard_display_sequencer #(
    parameter int NUM_PLAYERS  = 2,
    parameter int BLINK_TIME   = 500,
    parameter int DISPLAY_TIME = 2000,
    parameter int BLINK_COUNT  = 3,
    parameter int TIMER_W      = 12
) (
    input  logic                     clk_1khz,
    input  logic                     rst_ni,
    input  logic [4*NUM_PLAYERS-1:0] score_tens_i,
    input  logic [4*NUM_PLAYERS-1:0] score_ones_i,
    input  logic                     hold_i,
    input  logic                     skip_i,
    output logic [3:0]               tens_o,
    output logic [3:0]               ones_o,
    output logic [2:0]               active_o,
    output logic                     new_player_o
);

    localparam int FLASH_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
    localparam logic [TIMER_W-1:0] BLINK_LAST   = TIMER_W'(BLINK_TIME - 1);
    localparam logic [TIMER_W-1:0] DISPLAY_LAST = TIMER_W'(DISPLAY_TIME - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST   = FLASH_W'(BLINK_COUNT - 1);
    localparam logic [2:0]         PLAYER_LAST  = 3'(NUM_PLAYERS - 1);
    localparam logic [3:0]         CODE_BLANK   = 4'd10;
    localparam logic [3:0]         CODE_P       = 4'd11;

    typedef enum logic [1:0] {BLINK_ON, BLINK_OFF, SCORE} phase_t;

    phase_t               phase_q, phase_d;
    logic [2:0]           player_q, player_d, player_next;
    logic [FLASH_W-1:0]   flash_q, flash_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [3:0]           tens_d, ones_d, tens_raw, ones_raw;
    logic                 new_player_d;

    function automatic logic [3:0] sanitize(input logic [3:0] digit);
        return (digit > 4'd9) ? CODE_BLANK : digit;
    endfunction

    always_comb begin
        phase_d      = phase_q;
        player_d     = player_q;
        flash_d      = flash_q;
        timer_d      = timer_q;
        new_player_d = 1'b0;
        player_next  = (player_q == PLAYER_LAST) ? 3'd0 : player_q + 3'd1;

        // Skip overrides both the timer and hold, advancing exactly one player.
        if (skip_i) begin
            phase_d      = BLINK_ON;
            player_d     = player_next;
            flash_d      = '0;
            timer_d      = '0;
            new_player_d = 1'b1;
        end else begin
            case (phase_q)
                BLINK_ON: begin
                    if (timer_q == BLINK_LAST) begin
                        phase_d = BLINK_OFF;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                BLINK_OFF: begin
                    if (timer_q == BLINK_LAST) begin
                        timer_d = '0;
                        if (flash_q == FLASH_LAST) begin
                            phase_d = SCORE;
                            flash_d = '0;
                        end else begin
                            phase_d = BLINK_ON;
                            flash_d = flash_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    if (!hold_i) begin
                        if (timer_q == DISPLAY_LAST) begin
                            phase_d      = BLINK_ON;
                            player_d     = player_next;
                            timer_d      = '0;
                            new_player_d = 1'b1;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
            endcase
        end

        // Outputs are decoded from the next state so they register on the same edge.
        tens_raw = '0;
        ones_raw = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (player_d == 3'(p)) begin
                tens_raw = score_tens_i[4*p +: 4];
                ones_raw = score_ones_i[4*p +: 4];
            end
        end

        case (phase_d)
            BLINK_ON: begin
                tens_d = CODE_P;
                ones_d = {1'b0, player_d} + 4'd1;
            end
            BLINK_OFF: begin
                tens_d = CODE_BLANK;
                ones_d = CODE_BLANK;
            end
            default: begin
                tens_d = sanitize(tens_raw);
                ones_d = sanitize(ones_raw);
            end
        endcase
    end

    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q      <= BLINK_ON;
            player_q     <= '0;
            flash_q      <= '0;
            timer_q      <= '0;
            tens_o       <= CODE_P;
            ones_o       <= 4'd1;
            new_player_o <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            player_q     <= player_d;
            flash_q      <= flash_d;
            timer_q      <= timer_d;
            tens_o       <= tens_d;
            ones_o       <= ones_d;
            new_player_o <= new_player_d;
        end
    end

    assign active_o = player_q;

endmodule

// File: tb/tb_scoreboard_display_sequencer.sv
// Directed, table-driven bench for scoreboard_display_sequencer with 3 players,
// short blink/score intervals and hand-written hold/skip/reset sequences.
module tb_scoreboard_display_sequencer;

    localparam int NP = 3;

    logic          clk_1khz = 1'b0;
    logic          rst_ni   = 1'b0;
    logic [4*NP-1:0] score_tens_i;
    logic [4*NP-1:0] score_ones_i;
    logic          hold_i   = 1'b0;
    logic          skip_i   = 1'b0;
    logic [3:0]    tens_o;
    logic [3:0]    ones_o;
    logic [2:0]    active_o;
    logic          new_player_o;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;

    typedef struct {
        int         edge_n;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [2:0] active;
        logic       newp;
    } vec_t;

    vec_t free_run[14];

    localparam logic [4*NP-1:0] TENS_DEFAULT = {4'd9, 4'd4, 4'd3};
    localparam logic [4*NP-1:0] ONES_DEFAULT = {4'd0, 4'd2, 4'd5};

    scoreboard_display_sequencer #(
        .NUM_PLAYERS (NP),
        .BLINK_TIME  (3),
        .DISPLAY_TIME(5),
        .BLINK_COUNT (2),
        .TIMER_W     (4)
    ) dut (
        .clk_1khz    (clk_1khz),
        .rst_ni      (rst_ni),
        .score_tens_i(score_tens_i),
        .score_ones_i(score_ones_i),
        .hold_i      (hold_i),
        .skip_i      (skip_i),
        .tens_o      (tens_o),
        .ones_o      (ones_o),
        .active_o    (active_o),
        .new_player_o(new_player_o)
    );

    always #5 clk_1khz = ~clk_1khz;

    task automatic applyStimulus(input logic [4*NP-1:0] tens, input logic [4*NP-1:0] ones,
                                 input logic hold, input logic skip);
        score_tens_i = tens;
        score_ones_i = ones;
        hold_i       = hold;
        skip_i       = skip;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] tens, input logic [3:0] ones,
                               input logic [2:0] active, input logic newp);
        vectors++;
        if (tens_o !== tens || ones_o !== ones || active_o !== active || new_player_o !== newp) begin
            miscompares++;
            $display("[TB] FAIL %s @edge %0d: got tens=%0d ones=%0d active=%0d new=%0b, expected tens=%0d ones=%0d active=%0d new=%0b",
                     name, edge_cnt, tens_o, ones_o, active_o, new_player_o, tens, ones, active, newp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1khz);
        @(negedge clk_1khz);
        edge_cnt++;
    endtask

    task automatic tick_to(input int n);
        while (edge_cnt < n) tick();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous values, then releases on a negedge (edge 0).
    task automatic do_reset(input string name);
        @(negedge clk_1khz);
        #2 rst_ni = 1'b0;
        #1 checkOutput(name, 4'd11, 4'd1, 3'd0, 1'b0);
        repeat (2) @(negedge clk_1khz);
        rst_ni   = 1'b1;
        edge_cnt = 0;
    endtask

    task automatic run_free_table(input string name);
        for (int i = 0; i < 14; i++) begin
            tick_to(free_run[i].edge_n);
            checkOutput($sformatf("%s[%0d]", name, i), free_run[i].tens, free_run[i].ones,
                        free_run[i].active, free_run[i].newp);
        end
    endtask

    initial begin
        free_run[0]  = '{0,  4'd11, 4'd1,  3'd0, 1'b0};
        free_run[1]  = '{2,  4'd11, 4'd1,  3'd0, 1'b0};
        free_run[2]  = '{3,  4'd10, 4'd10, 3'd0, 1'b0};
        free_run[3]  = '{5,  4'd10, 4'd10, 3'd0, 1'b0};
        free_run[4]  = '{6,  4'd11, 4'd1,  3'd0, 1'b0};
        free_run[5]  = '{9,  4'd10, 4'd10, 3'd0, 1'b0};
        free_run[6]  = '{12, 4'd3,  4'd5,  3'd0, 1'b0};
        free_run[7]  = '{16, 4'd3,  4'd5,  3'd0, 1'b0};
        free_run[8]  = '{17, 4'd11, 4'd2,  3'd1, 1'b1};
        free_run[9]  = '{18, 4'd11, 4'd2,  3'd1, 1'b0};
        free_run[10] = '{23, 4'd11, 4'd2,  3'd1, 1'b0};
        free_run[11] = '{29, 4'd4,  4'd2,  3'd1, 1'b0};
        free_run[12] = '{34, 4'd11, 4'd3,  3'd2, 1'b1};
        free_run[13] = '{51, 4'd11, 4'd1,  3'd0, 1'b1};

        applyStimulus(TENS_DEFAULT, ONES_DEFAULT, 1'b0, 1'b0);

        // Reset and free run over three full player periods.
        do_reset("reset_async");
        run_free_table("free_run");

        // Score tracking with one-edge latency and sanitising of player 1's digits.
        tick_to(80);
        checkOutput("score_p1", 4'd4, 4'd2, 3'd1, 1'b0);
        applyStimulus(TENS_DEFAULT, {4'd0, 4'd7, 4'd5}, 1'b0, 1'b0);
        tick();
        checkOutput("score_track", 4'd4, 4'd7, 3'd1, 1'b0);
        applyStimulus({4'd9, 4'd12, 4'd3}, {4'd0, 4'd7, 4'd5}, 1'b0, 1'b0);
        tick();
        checkOutput("score_sanitize", 4'd10, 4'd7, 3'd1, 1'b0);
        applyStimulus(TENS_DEFAULT, ONES_DEFAULT, 1'b0, 1'b0);
        tick_to(85);
        checkOutput("after_score_p1", 4'd11, 4'd3, 3'd2, 1'b1);

        // Hold asserted before SCORE entry freezes the timer at 0 for 40 cycles.
        do_reset("reset_hold");
        tick_to(11);
        applyStimulus(TENS_DEFAULT, ONES_DEFAULT, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
            checkOutput("hold_frozen", 4'd3, 4'd5, 3'd0, 1'b0);
        end
        applyStimulus(TENS_DEFAULT, ONES_DEFAULT, 1'b0, 1'b0);
        tick_to(55);
        checkOutput("hold_last_score", 4'd3, 4'd5, 3'd0, 1'b0);
        tick();
        checkOutput("hold_resume_next", 4'd11, 4'd2, 3'd1, 1'b1);

        // Skip from player 2's BLINK_OFF wraps to player 0.
        do_reset("reset_skip");
        tick_to(37);
        checkOutput("p2_blink_off", 4'd10, 4'd10, 3'd2, 1'b0);
        applyStimulus(TENS_DEFAULT, ONES_DEFAULT, 1'b0, 1'b1);
        tick();
        applyStimulus(TENS_DEFAULT, ONES_DEFAULT, 1'b0, 1'b0);
        checkOutput("skip_wrap", 4'd11, 4'd1, 3'd0, 1'b1);
        tick();
        checkOutput("skip_pulse_end", 4'd11, 4'd1, 3'd0, 1'b0);
        tick_to(41);
        checkOutput("skip_restart_timing", 4'd10, 4'd10, 3'd0, 1'b0);

        // Skip on the last SCORE cycle advances by exactly one player.
        do_reset("reset_skip_exp");
        tick_to(16);
        applyStimulus(TENS_DEFAULT, ONES_DEFAULT, 1'b1, 1'b1);
        tick();
        applyStimulus(TENS_DEFAULT, ONES_DEFAULT, 1'b0, 1'b0);
        checkOutput("skip_expiry", 4'd11, 4'd2, 3'd1, 1'b1);
        tick_to(20);
        checkOutput("skip_expiry_off", 4'd10, 4'd10, 3'd1, 1'b0);
        tick_to(23);
        checkOutput("skip_expiry_flash2", 4'd11, 4'd2, 3'd1, 1'b0);

        // Reset during player 1's SCORE, then the free-run timing repeats.
        tick_to(30);
        checkOutput("pre_reset_score", 4'd4, 4'd2, 3'd1, 1'b0);
        do_reset("reset_mid");
        run_free_table("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
